// File: rtl/imem_prefetch_buffer.sv
// imem_prefetch_buffer: sequential instruction prefetch FIFO with redirect/drain handling.
// Define IMEM_PREFETCH_PERF_EN to add saturating redirect and stall counters.
`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif
module imem_prefetch_buffer #(
  parameter int DEPTH = 4,
  parameter logic [`RISCV_ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         redirect_i,
  input  logic [`RISCV_ADDR_WIDTH-1:0] redirect_addr_i,
  output logic                         instr_valid_o,
  input  logic                         instr_ready_i,
  output logic [`RISCV_WORD_WIDTH-1:0] instr_o,
  output logic [`RISCV_ADDR_WIDTH-1:0] instr_addr_o,
  output logic                         mem_valid_o,
  input  logic                         mem_ready_i,
  output logic [`RISCV_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [`RISCV_WORD_WIDTH-1:0] mem_wdata_o,
  output logic [3:0]                   mem_we_o,
  input  logic [`RISCV_WORD_WIDTH-1:0] mem_rdata_i
`ifdef IMEM_PREFETCH_PERF_EN
  ,
  output logic [31:0]                  perf_redirect_cnt_o,
  output logic [31:0]                  perf_stall_cnt_o
`endif
);
  localparam int A = `RISCV_ADDR_WIDTH;
  localparam int W = `RISCV_WORD_WIDTH;
  localparam int PW = $clog2(DEPTH);
  typedef enum logic {RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic live;
  logic [PW:0] count;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [A-1:0] fetch_pc, fetch_pc_nx, pending_pc, pending_pc_nx, redirect_pc;
  logic [W-1:0] data_q [DEPTH];
  logic [A-1:0] pc_q [DEPTH];
  logic accept, pop, push, unused_bits;
  assign unused_bits = ^redirect_addr_i[1:0];
  assign redirect_pc = {redirect_addr_i[A-1:2], 2'b00};
  // live keeps the request low while in reset; count<=DEPTH so its MSB flags full
  assign mem_valid_o = live && (state == DRAIN || !count[PW]);
  assign mem_addr_o = fetch_pc;
  assign mem_wdata_o = '0;
  assign mem_we_o = 4'b0000;
  assign accept = mem_valid_o && mem_ready_i;
  assign instr_valid_o = count != '0;
  assign pop = instr_valid_o && instr_ready_i;
  assign push = accept && state == RUN && !redirect_i;
  assign instr_o = data_q[rd_ptr];
  assign instr_addr_o = pc_q[rd_ptr];
  always_comb begin
    state_nx = state;
    fetch_pc_nx = fetch_pc;
    pending_pc_nx = pending_pc;
    if (state == RUN) begin
      if (redirect_i && mem_valid_o && !mem_ready_i) begin
        state_nx = DRAIN;
        pending_pc_nx = redirect_pc;
      end else if (redirect_i) fetch_pc_nx = redirect_pc;
      else if (accept) fetch_pc_nx = fetch_pc + A'(4);
    end else if (accept) begin
      state_nx = RUN;
      fetch_pc_nx = redirect_i ? redirect_pc : pending_pc;
    end else if (redirect_i) pending_pc_nx = redirect_pc;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      live <= 1'b0;
      fetch_pc <= RESET_ADDR;
      pending_pc <= RESET_ADDR;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      state <= state_nx;
      live <= 1'b1;
      fetch_pc <= fetch_pc_nx;
      pending_pc <= pending_pc_nx;
      if (redirect_i) begin
        count <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        count <= count + (PW+1)'(push) - (PW+1)'(pop);
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop) rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i] <= '0;
      end
    end else if (push) begin
      data_q[wr_ptr] <= mem_rdata_i;
      pc_q[wr_ptr] <= fetch_pc;
    end
  end
`ifdef IMEM_PREFETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_redirect_cnt_o <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      if (redirect_i && perf_redirect_cnt_o != '1) perf_redirect_cnt_o <= perf_redirect_cnt_o + 32'd1;
      if (instr_ready_i && !instr_valid_o && perf_stall_cnt_o != '1) perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_imem_prefetch_buffer.sv
// tb_imem_prefetch_buffer: queue-based reference model with per-cycle compare plus directed literal checks.
module tb_imem_prefetch_buffer;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst_n = 1'b0, redirect = 1'b0, instr_ready = 1'b0, mem_ready = 1'b0;
  logic [31:0] redirect_addr = '0, instr, instr_addr, mem_addr, mem_wdata, mem_rdata;
  logic instr_valid, mem_valid;
  logic [3:0] mem_we;
  int checks = 0, passed = 0;
  always #5 clk = ~clk;

  imem_prefetch_buffer #(.DEPTH(DEPTH), .RESET_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .redirect_i(redirect), .redirect_addr_i(redirect_addr),
    .instr_valid_o(instr_valid), .instr_ready_i(instr_ready), .instr_o(instr), .instr_addr_o(instr_addr),
    .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_we_o(mem_we), .mem_rdata_i(mem_rdata)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction
  assign mem_rdata = word_of(mem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the FIFO is a queue of {pc, word}; a stalled request across a redirect is a drain flag.
  logic [63:0] q[$];
  logic [31:0] m_pc = '0, m_pend = '0, tgt;
  bit m_drain = 0, m_live = 0, mv, acc;
  logic [31:0] acc_log[$], deliv[$];

  function automatic bit m_mval();
    return m_live && (m_drain || q.size() < DEPTH);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_pc = '0;
      m_pend = '0;
      m_drain = 0;
      m_live = 0;
    end else begin
      mv = m_mval();
      acc = mv && mem_ready;
      tgt = {redirect_addr[31:2], 2'b00};
      if (mem_valid && mem_ready) acc_log.push_back(mem_addr);
      if (instr_valid && instr_ready) deliv.push_back(instr_addr);
      if (redirect) begin
        q.delete();
        if (m_drain) begin
          if (acc) begin m_drain = 0; m_pc = tgt; end
          else m_pend = tgt;
        end else if (mv && !mem_ready) begin
          m_drain = 1;
          m_pend = tgt;
        end else m_pc = tgt;
      end else begin
        if (q.size() != 0 && instr_ready) void'(q.pop_front());
        if (m_drain) begin
          if (acc) begin m_drain = 0; m_pc = m_pend; end
        end else if (acc) begin
          q.push_back({m_pc, word_of(m_pc)});
          m_pc = m_pc + 32'd4;
        end
      end
      m_live = 1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
      chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_instr_addr", instr_addr, 32'h0);
    end else begin
      chk("mem_valid", {31'b0, mem_valid}, {31'b0, m_mval()});
      if (m_mval()) chk("mem_addr", mem_addr, m_pc);
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, q.size() != 0});
      if (q.size() != 0) begin
        chk("instr_addr", instr_addr, q[0][63:32]);
        chk("instr", instr, q[0][31:0]);
      end
      chk("mem_we_wdata", {28'b0, mem_we} | mem_wdata, 32'h0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    acc_log.delete();
    deliv.delete();
  endtask

  task automatic restart();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    clear_logs();
  endtask

  initial begin
    tick(3);
    chk("lit_rst_mem_addr", mem_addr, 32'h0);
    // streaming from reset
    mem_ready = 1'b1;
    instr_ready = 1'b1;
    rst_n = 1'b1;
    clear_logs();
    tick(1);
    chk("lit_p1_req_valid", {31'b0, mem_valid}, 32'd1);
    chk("lit_p1_req_addr", mem_addr, 32'h0);
    tick(1);
    chk("lit_p1_head_valid", {31'b0, instr_valid}, 32'd1);
    chk("lit_p1_head_addr", instr_addr, 32'h0);
    chk("lit_p1_next_req", mem_addr, 32'h4);
    tick(4);
    chk("lit_p1_acc1", acc_log[1], 32'h4);
    chk("lit_p1_acc2", acc_log[2], 32'h8);
    chk("lit_p1_deliv2", deliv[2], 32'h8);
    chk("lit_p1_deliv_n", 32'(deliv.size()), 32'd4);
    // fill to full with the core stalled
    instr_ready = 1'b0;
    restart();
    tick(10);
    chk("lit_p2_acc_n", 32'(acc_log.size()), 32'd4);
    chk("lit_p2_acc3", acc_log[3], 32'hC);
    chk("lit_p2_full_idle", {31'b0, mem_valid}, 32'd0);
    instr_ready = 1'b1;
    clear_logs();
    tick(6);
    chk("lit_p2_resume", acc_log[0], 32'h10);
    chk("lit_p2_deliv0", deliv[0], 32'h0);
    chk("lit_p2_deliv4", deliv[4], 32'h10);
    // redirect while request accepted
    redirect = 1'b1;
    redirect_addr = 32'h103;
    tick(1);
    redirect = 1'b0;
    chk("lit_p3_empty", {31'b0, instr_valid}, 32'd0);
    chk("lit_p3_addr", mem_addr, 32'h100);
    clear_logs();
    tick(4);
    chk("lit_p3_deliv0", deliv[0], 32'h100);
    // redirect while request stalled
    restart();
    tick(3);
    chk("lit_p4_pre", mem_addr, 32'h8);
    mem_ready = 1'b0;
    redirect = 1'b1;
    redirect_addr = 32'h200;
    tick(1);
    redirect = 1'b0;
    clear_logs();
    chk("lit_p4_hold0", mem_addr, 32'h8);
    chk("lit_p4_hold_valid", {31'b0, mem_valid}, 32'd1);
    tick(1);
    chk("lit_p4_hold1", mem_addr, 32'h8);
    tick(1);
    mem_ready = 1'b1;
    tick(1);
    chk("lit_p4_new", mem_addr, 32'h200);
    chk("lit_p4_discard", {31'b0, instr_valid}, 32'd0);
    tick(3);
    chk("lit_p4_deliv0", deliv[0], 32'h200);
    // two redirects while draining
    restart();
    tick(3);
    mem_ready = 1'b0;
    redirect = 1'b1;
    redirect_addr = 32'h300;
    tick(1);
    redirect_addr = 32'h400;
    tick(1);
    redirect = 1'b0;
    clear_logs();
    tick(1);
    mem_ready = 1'b1;
    tick(1);
    chk("lit_p5_addr", mem_addr, 32'h400);
    tick(3);
    chk("lit_p5_acc1", acc_log[1], 32'h400);
    chk("lit_p5_deliv0", deliv[0], 32'h400);
    // redirect in drain coinciding with the accept
    mem_ready = 1'b0;
    redirect = 1'b1;
    redirect_addr = 32'h500;
    tick(1);
    redirect_addr = 32'h600;
    mem_ready = 1'b1;
    tick(1);
    redirect = 1'b0;
    chk("lit_p5b_addr", mem_addr, 32'h600);
    tick(2);
    // address wrap
    redirect = 1'b1;
    redirect_addr = 32'hFFFF_FFFF;
    tick(1);
    redirect = 1'b0;
    clear_logs();
    tick(3);
    chk("lit_p6_acc0", acc_log[0], 32'hFFFF_FFFC);
    chk("lit_p6_wrap", acc_log[1], 32'h0);
    chk("lit_p6_acc2", acc_log[2], 32'h4);
    // reset mid-stream
    rst_n = 1'b0;
    #1;
    chk("lit_p7_rst_valid", {31'b0, mem_valid}, 32'd0);
    chk("lit_p7_rst_ivalid", {31'b0, instr_valid}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    clear_logs();
    tick(3);
    chk("lit_p7_restart0", acc_log[0], 32'h0);
    chk("lit_p7_restart1", acc_log[1], 32'h4);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/imem_prefetch_buffer.md
Name: imem_prefetch_buffer

Overview:
- Instruction prefetch stage between the core's fetch/decode front end and instruction port A of the dual-port RAM.
- Issues sequential word fetches ahead of the core and buffers up to DEPTH instructions in a FIFO.
- Hands instructions and their PCs to the core over a valid/ready interface.
- Flushes and restarts from a new address on a redirect (branch, jump or trap).

Parameters:
- DEPTH, 4: FIFO entries. Power of two, 2..16.
- RESET_ADDR, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- redirect_i  input  1  flush and restart fetch
- redirect_addr_i  input  `RISCV_ADDR_WIDTH  new fetch PC; bits [1:0] ignored
- instr_valid_o  output  1  FIFO head valid
- instr_ready_i  input  1  core accepts head
- instr_o  output  `RISCV_WORD_WIDTH  head instruction word
- instr_addr_o  output  `RISCV_ADDR_WIDTH  head instruction PC
- mem_valid_o  output  1  fetch request
- mem_ready_i  input  1  request accepted; mem_rdata_i valid this cycle
- mem_addr_o  output  `RISCV_ADDR_WIDTH  fetch address, word aligned
- mem_wdata_o  output  `RISCV_WORD_WIDTH  tied 0
- mem_we_o  output  4  tied 4'b0000
- mem_rdata_i  input  `RISCV_WORD_WIDTH  fetched word

Behaviour:
- Reset values: instr_valid_o=0, instr_o=0, instr_addr_o=0, mem_valid_o=0, mem_addr_o=RESET_ADDR. Internal reset: count=0, fetch_pc=RESET_ADDR, state=RUN.
- Memory handshake:
  - A transfer completes when mem_valid_o && mem_ready_i; the response word is sampled in that same cycle.
  - Once raised, mem_valid_o and mem_addr_o stay stable until the request is accepted. This holds even across a redirect.
- States:
  - RUN: mem_valid_o = (count < DEPTH); mem_addr_o = fetch_pc.
    - On accept: push {fetch_pc, mem_rdata_i} and set fetch_pc += 4. fetch_pc wraps modulo 2^ADDR_WIDTH.
  - DRAIN: mem_valid_o=1 with the old address, held stable.
    - On accept: discard the response, set fetch_pc = pending_pc, go to RUN.
- Core handshake:
  - Pop when instr_valid_o && instr_ready_i.
  - instr_valid_o = (count != 0), registered FIFO head; there is no bypass.
  - Minimum latency: memory accept in cycle N gives instr_valid_o in cycle N+1.
  - Push and pop in the same cycle: count unchanged. This is legal at count==DEPTH only when the pop frees a slot; the full check uses the pre-pop count, so no request is issued that cycle.
- Redirect (registered effect; takes priority over push):
  - FIFO cleared: count=0, pointers=0, and instr_valid_o=0 next cycle. A pop in the redirect cycle is still a valid handshake.
  - RUN with no outstanding request, or with the request accepted this cycle: the response is discarded, fetch_pc = {redirect_addr_i[ADDR-1:2], 2'b00}, and the state stays RUN. The first new request is in the next cycle.
  - RUN with mem_valid_o=1 and mem_ready_i=0: pending_pc = aligned redirect_addr_i; go to DRAIN.
  - In DRAIN: a further redirect overwrites pending_pc. If the old request is accepted in that same cycle, go directly to RUN with the newest address.
- Reset asserted mid-operation: all state returns immediately to reset values, and any in-flight memory request is abandoned.
- Full: no request is issued while count==DEPTH. A request already raised is never withdrawn, because count cannot grow without an accept.

Optional Feature:
- IMEM_PREFETCH_PERF_EN defined:
  - Adds outputs perf_redirect_cnt_o[31:0], counting redirect cycles.
  - Adds perf_stall_cnt_o[31:0], counting cycles with instr_ready_i=1 and instr_valid_o=0.
  - Both counters reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release with mem_ready_i=1 constant and instr_ready_i=1 → fetch addresses 0x0, 0x4, 0x8 on consecutive cycles; instr_addr_o 0x0 appears one cycle after its accept; one instruction per cycle thereafter.
- instr_ready_i=0 with DEPTH=4 → exactly 4 accepts (0x0–0xC), then mem_valid_o=0; raise instr_ready_i → fetch resumes at 0x10, order preserved.
- Redirect to 0x103 while mem_ready_i=1 → next request address 0x100; FIFO empty next cycle; no stale word delivered.
- Redirect to 0x200 while request 0x8 is stalled (mem_ready_i=0 for 3 cycles) → mem_addr_o stays 0x8 until accepted; word discarded; next request 0x200.
- Two redirects in DRAIN (0x300, then 0x400) → only 0x400 fetched after the drain completes.
- fetch_pc = 0xFFFF_FFFC with 32-bit address → next fetch 0x0000_0000; rst_n pulse mid-stream → outputs at reset values, restart at RESET_ADDR.
